// File: rtl/binary_frame_buffer_if.sv
// Bus bundle for binary_frame_buffer.
//   master : pixel writer / row reader / control side (drives WE..RD_Y)
//   slave  : the frame buffer itself (drives BUSY..OOB_ERR)
// Signals: WE/X/Y/PIX pixel write, SWAP/CLEAR bank control, BUSY/BANK status,
// RD_EN/RD_Y row read request, RD_ROW/RD_VALID row data, ONES_CNT set-pixel
// count of the read bank, OOB_ERR sticky out-of-range flag.
interface binary_frame_buffer_if #(
  parameter int IMG_W = 300,
  parameter int IMG_H = 150,
  parameter int CW    = 10,
  parameter int NW    = $clog2(IMG_W*IMG_H+1)
) ();
  logic             WE;
  logic [CW-1:0]    X;
  logic [CW-1:0]    Y;
  logic             PIX;
  logic             SWAP;
  logic             CLEAR;
  logic             BUSY;
  logic             BANK;
  logic             RD_EN;
  logic [CW-1:0]    RD_Y;
  logic [IMG_W-1:0] RD_ROW;
  logic             RD_VALID;
  logic [NW-1:0]    ONES_CNT;
  logic             OOB_ERR;

  modport master (
    output WE, X, Y, PIX, SWAP, CLEAR, RD_EN, RD_Y,
    input  BUSY, BANK, RD_ROW, RD_VALID, ONES_CNT, OOB_ERR
  );

  modport slave (
    input  WE, X, Y, PIX, SWAP, CLEAR, RD_EN, RD_Y,
    output BUSY, BANK, RD_ROW, RD_VALID, ONES_CNT, OOB_ERR
  );
endinterface

// File: rtl/binary_frame_buffer.sv
// Double-buffered 1-bit-per-pixel frame store.
// Ports:
//   CLK   : single rising-edge clock
//   RESET : asynchronous active-high reset (clears all storage and state)
//   bus   : binary_frame_buffer_if.slave -- pixel writes into the write bank
//           (BANK), row reads from the read bank (!BANK), SWAP/CLEAR control,
//           BUSY during the clear sweep, ONES_CNT of the read bank, OOB_ERR.
module binary_frame_buffer #(
  parameter int IMG_W = 300,
  parameter int IMG_H = 150,
  parameter int CW    = 10,
  parameter int NW    = $clog2(IMG_W*IMG_H+1)
) (
  input  logic CLK,
  input  logic RESET,
  binary_frame_buffer_if.slave bus
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic {ST_IDLE, ST_CLR} state_e;

  state_e           state_q, state_d;
  logic [YW-1:0]    rp_q, rp_d;
  logic             bank_q, bank_d;
  logic             pend_q, pend_d;
  logic             oob_q, oob_d;
  logic             rd_valid_q, rd_valid_d;
  logic [IMG_W-1:0] rd_row_q, rd_row_d;
  logic [NW-1:0]    cnt_q [2];
  logic [NW-1:0]    cnt_d [2];
  logic [IMG_W-1:0] mem_q [2][IMG_H];

  logic             wr_en, clr_en;
  logic             wr_in_rng, rd_in_rng;
  logic             old_bit, clr_bank;
  logic [XW-1:0]    x_idx;
  logic [YW-1:0]    y_idx, rd_idx;

  assign x_idx     = bus.X[XW-1:0];
  assign y_idx     = bus.Y[YW-1:0];
  assign rd_idx    = bus.RD_Y[YW-1:0];
  assign wr_in_rng = (bus.X < CW'(IMG_W)) && (bus.Y < CW'(IMG_H));
  assign rd_in_rng = (bus.RD_Y < CW'(IMG_H));

  always_comb begin
    state_d    = state_q;
    rp_d       = rp_q;
    bank_d     = bank_q;
    pend_d     = pend_q;
    oob_d      = oob_q;
    cnt_d      = cnt_q;
    rd_row_d   = rd_row_q;
    rd_valid_d = 1'b0;
    wr_en      = 1'b0;
    clr_en     = 1'b0;
    old_bit    = 1'b0;
    clr_bank   = bank_q;

    // Reads always sample the pre-swap read bank and run in both states.
    if (bus.RD_EN) begin
      if (rd_in_rng) begin
        rd_row_d   = mem_q[~bank_q][rd_idx];
        rd_valid_d = 1'b1;
      end else begin
        oob_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.CLEAR) begin
          // Swap resolves first so the sweep targets the new write bank;
          // a same-cycle write is dropped.
          clr_bank        = bank_q ^ bus.SWAP;
          bank_d          = clr_bank;
          cnt_d[clr_bank] = '0;
          rp_d            = '0;
          oob_d           = 1'b0;
          state_d         = ST_CLR;
        end else begin
          if (bus.WE) begin
            if (wr_in_rng) begin
              wr_en   = 1'b1;
              old_bit = mem_q[bank_q][y_idx][x_idx];
              if (old_bit != bus.PIX) begin
                cnt_d[bank_q] = bus.PIX ? cnt_q[bank_q] + NW'(1)
                                        : cnt_q[bank_q] - NW'(1);
              end
            end else begin
              oob_d = 1'b1;
            end
          end
          if (bus.SWAP) bank_d = ~bank_q;
        end
      end
      ST_CLR: begin
        clr_en = 1'b1;
        rp_d   = rp_q + YW'(1);
        if (bus.SWAP) pend_d = 1'b1;
        if (rp_q == YW'(IMG_H-1)) begin
          state_d = ST_IDLE;
          rp_d    = '0;
          pend_d  = 1'b0;
          if (pend_q || bus.SWAP) bank_d = ~bank_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      rp_q       <= '0;
      bank_q     <= 1'b0;
      pend_q     <= 1'b0;
      oob_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_row_q   <= '0;
      cnt_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      rp_q       <= rp_d;
      bank_q     <= bank_d;
      pend_q     <= pend_d;
      oob_q      <= oob_d;
      rd_valid_q <= rd_valid_d;
      rd_row_q   <= rd_row_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage is kept apart from the control registers; clr_en and wr_en are
  // mutually exclusive (one per FSM state), both aimed at the write bank.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_q <= '{default: '0};
    end else begin
      if (clr_en) mem_q[bank_q][rp_q] <= '0;
      if (wr_en)  mem_q[bank_q][y_idx][x_idx] <= bus.PIX;
    end
  end

  assign bus.BUSY     = (state_q == ST_CLR);
  assign bus.BANK     = bank_q;
  assign bus.RD_ROW   = rd_row_q;
  assign bus.RD_VALID = rd_valid_q;
  assign bus.ONES_CNT = cnt_q[~bank_q];
  assign bus.OOB_ERR  = oob_q;

endmodule

// File: tb/tb_binary_frame_buffer.sv
// Self-checking bench for binary_frame_buffer: directed scenarios plus a
// randomized phase, all compared against a whole-frame behavioural model.
module tb_binary_frame_buffer;
  localparam int IMG_W = 300;
  localparam int IMG_H = 150;
  localparam int CW    = 10;
  localparam int NW    = $clog2(IMG_W*IMG_H+1);

  typedef logic [IMG_W-1:0] row_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  binary_frame_buffer_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .NW(NW)) bus ();

  binary_frame_buffer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .NW(NW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: a clear zeroes the whole bank at once and a timer
  // stands in for the sweep; the count is recomputed from the bits.
  bit [IMG_W-1:0] m_mem [2][IMG_H];
  bit   m_bank, m_pend, m_oob, m_valid;
  int   m_busy;
  row_t m_row;

  function automatic int m_ones(input bit b);
    int s = 0;
    for (int r = 0; r < IMG_H; r++) s += $countones(m_mem[b][r]);
    return s;
  endfunction

  task automatic m_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < IMG_H; r++) m_mem[b][r] = '0;
    m_bank = 0; m_pend = 0; m_oob = 0; m_valid = 0; m_busy = 0; m_row = '0;
  endtask

  task automatic m_step(input bit we, input int x, input int y, input bit pix,
                        input bit swap, input bit clear, input bit rd_en, input int rd_y);
    if (rd_en && rd_y < IMG_H) begin
      m_row   = m_mem[!m_bank][rd_y];
      m_valid = 1;
    end else begin
      m_valid = 0;
      if (rd_en) m_oob = 1;
    end
    if (m_busy > 0) begin
      if (swap) m_pend = 1;
      m_busy--;
      if (m_busy == 0 && m_pend) begin
        m_bank = !m_bank;
        m_pend = 0;
      end
    end else if (clear) begin
      if (swap) m_bank = !m_bank;
      for (int r = 0; r < IMG_H; r++) m_mem[m_bank][r] = '0;
      m_busy = IMG_H;
      m_oob  = 0;
    end else begin
      if (we) begin
        if (x < IMG_W && y < IMG_H) m_mem[m_bank][y][x] = pix;
        else m_oob = 1;
      end
      if (swap) m_bank = !m_bank;
    end
  endtask

  task automatic chk(input string tag, input row_t obs, input row_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy",     row_t'(bus.BUSY),     row_t'(m_busy != 0));
    chk("bank",     row_t'(bus.BANK),     row_t'(m_bank));
    chk("rd_valid", row_t'(bus.RD_VALID), row_t'(m_valid));
    chk("rd_row",   bus.RD_ROW,           m_row);
    chk("ones_cnt", row_t'(bus.ONES_CNT), row_t'(m_ones(!m_bank)));
    chk("oob_err",  row_t'(bus.OOB_ERR),  row_t'(m_oob));
  endtask

  task automatic cyc(input bit we, input int x, input int y, input bit pix,
                     input bit swap, input bit clear, input bit rd_en, input int rd_y);
    bus.WE = we; bus.X = CW'(x); bus.Y = CW'(y); bus.PIX = pix;
    bus.SWAP = swap; bus.CLEAR = clear; bus.RD_EN = rd_en; bus.RD_Y = CW'(rd_y);
    @(posedge CLK);
    m_step(we, x, y, pix, swap, clear, rd_en, rd_y);
    #1;
    bus.WE = 0; bus.SWAP = 0; bus.CLEAR = 0; bus.RD_EN = 0; bus.PIX = 0;
    check_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int x, input int y, input bit pix);
    cyc(1, x, y, pix, 0, 0, 0, 0);
  endtask

  task automatic rd(input int y);
    cyc(0, 0, 0, 0, 0, 0, 1, y);
  endtask

  task automatic drain();
    for (int i = 0; i < IMG_H + 5 && m_busy != 0; i++) idle();
  endtask

  initial begin
    row_t exp_row;
    row_t old_row;
    int busy_cnt, toggle_k;
    bit bank0;

    // Reset state
    bus.WE = 0; bus.X = '0; bus.Y = '0; bus.PIX = 0; bus.SWAP = 0;
    bus.CLEAR = 0; bus.RD_EN = 0; bus.RD_Y = '0;
    RESET = 1;
    m_reset();
    #12;
    check_all();
    RESET = 0;

    // Single pixel write, swap, row readback
    wr(5, 3, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    rd(3);
    exp_row = '0; exp_row[5] = 1'b1;
    chk("t1_valid", row_t'(bus.RD_VALID), row_t'(1));
    chk("t1_row",   bus.RD_ROW, exp_row);
    chk("t1_ones",  row_t'(bus.ONES_CNT), row_t'(1));
    chk("t1_bank",  row_t'(bus.BANK), row_t'(1));

    // Same-value, clearing and neighbouring writes
    wr(10, 10, 1); wr(10, 10, 1); wr(10, 10, 0); wr(11, 10, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    rd(10);
    exp_row = '0; exp_row[11] = 1'b1;
    chk("t2_ones", row_t'(bus.ONES_CNT), row_t'(1));
    chk("t2_row",  bus.RD_ROW, exp_row);

    // Fill 20 ones, clear with WE every sweep cycle, SWAP at sweep cycle 50
    for (int i = 0; i < 20; i++) wr(i * 7, i * 3, 1);
    bank0 = bus.BANK;
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    busy_cnt = bus.BUSY ? 1 : 0;
    toggle_k = -1;
    for (int k = 1; k <= 200; k++) begin
      cyc(1, $urandom_range(0, 400), $urandom_range(0, 200), 1'($urandom), k == 50, 0, 0, 0);
      if (toggle_k < 0 && bus.BANK != bank0) toggle_k = k;
      if (bus.BUSY) busy_cnt++;
      else break;
    end
    chk("t3_busy_cycles", row_t'(busy_cnt), row_t'(IMG_H));
    chk("t3_swap_edge",   row_t'(toggle_k), row_t'(IMG_H));
    chk("t3_ones",        row_t'(bus.ONES_CNT), row_t'(0));
    chk("t3_oob",         row_t'(bus.OOB_ERR), row_t'(0));
    for (int r = 0; r < IMG_H; r++) begin
      rd(r);
      chk("t3_row_zero", bus.RD_ROW, '0);
    end

    // Out-of-range accesses
    wr(300, 0, 1);
    chk("t4_oob_x", row_t'(bus.OOB_ERR), row_t'(1));
    wr(0, 150, 1);
    rd(200);
    chk("t4_rd_valid", row_t'(bus.RD_VALID), row_t'(0));
    chk("t4_oob_hold", row_t'(bus.OOB_ERR), row_t'(1));
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    chk("t4_ones_unch", row_t'(bus.ONES_CNT), row_t'(m_ones(!m_bank)));
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("t4_oob_clr", row_t'(bus.OOB_ERR), row_t'(0));
    drain();

    // Same-cycle WE + SWAP + RD_EN
    wr(7, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    wr(0, 0, 0);
    old_row = m_mem[!m_bank][0];
    cyc(1, 0, 0, 1, 1, 0, 1, 0);
    chk("t5_old_bank", bus.RD_ROW, old_row);
    rd(0);
    chk("t5_bit0", row_t'(bus.RD_ROW[0]), row_t'(1));
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    rd(0);
    chk("t5_bit0_again", row_t'(bus.RD_ROW[0]), row_t'(1));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int x, y;
      x = ($urandom_range(0, 31) == 0) ? $urandom_range(300, 1023) : $urandom_range(0, 20);
      y = ($urandom_range(0, 31) == 0) ? $urandom_range(150, 1023) : $urandom_range(0, 10);
      cyc(1'($urandom_range(0, 2) != 0), x, y, 1'($urandom),
          $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0,
          1'($urandom), ($urandom_range(0, 31) == 0) ? 160 : $urandom_range(0, 10));
    end
    drain();

    // Asynchronous reset in the middle of a sweep
    for (int i = 0; i < 10; i++) wr(i, i, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i < 75; i++) idle();
    #2;
    RESET = 1;
    #1;
    m_reset();
    chk("t6_busy", row_t'(bus.BUSY), row_t'(0));
    chk("t6_bank", row_t'(bus.BANK), row_t'(0));
    chk("t6_ones", row_t'(bus.ONES_CNT), row_t'(0));
    check_all();
    #2;
    RESET = 0;
    for (int r = 0; r < IMG_H; r++) rd(r);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    for (int r = 0; r < IMG_H; r++) begin
      rd(r);
      chk("t6_row_zero", bus.RD_ROW, '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
